// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write bus between the boot loader and its neighbours.
// The master modport is the stream source / memory side; the slave modport is the loader.
interface program_loader_if #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 32
);
  logic              start_PL;
  logic [7:0]        rxData_PL;
  logic              rxValid_PL;
  logic              rxReady_OUT;
  logic              imWe_OUT;
  logic [ADDR_W-1:0] imAddr_OUT;
  logic [WORD_W-1:0] imData_OUT;
  logic              coreReset_OUT;
  logic              done_OUT;
  logic              error_OUT;

  modport master (
    output start_PL, rxData_PL, rxValid_PL,
    input  rxReady_OUT, imWe_OUT, imAddr_OUT, imData_OUT,
    input  coreReset_OUT, done_OUT, error_OUT
  );

  modport slave (
    input  start_PL, rxData_PL, rxValid_PL,
    output rxReady_OUT, imWe_OUT, imAddr_OUT, imData_OUT,
    output coreReset_OUT, done_OUT, error_OUT
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: length byte, little-endian words into instruction memory, XOR checksum byte.
// Keeps the core in reset until an image has been loaded and verified.
module program_loader #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 32
) (
  input  logic           clk_PL,
  input  logic           reset_PL,
  program_loader_if.slave bus
);
  localparam int         CNT_W   = ADDR_W + 1;
  localparam logic [8:0] MAX_LEN = 9'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_rx_ready;
  logic              r_done;
  logic              r_error;
  logic              r_core_rst;
  logic              r_im_we;
  logic [ADDR_W-1:0] r_im_addr;
  logic [WORD_W-1:0] r_im_data;
  logic [WORD_W-1:0] r_word;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [ADDR_W-1:0] r_word_idx;
  logic [1:0]        r_byte_idx;
  logic [7:0]        r_chk;
  logic              w_rx_ready_nx;
  logic              w_done_nx;
  logic              w_error_nx;
  logic              w_core_rst_nx;
  logic              w_accept;
  logic              w_len_bad;
  logic              w_last_byte;
  logic              w_last_word;

  function automatic logic [7:0] f_xor8(input logic [7:0] a, input logic [7:0] b);
    return a ^ b;
  endfunction

  assign w_accept    = bus.rxValid_PL & r_rx_ready;
  assign w_len_bad   = (bus.rxData_PL == 8'd0) || ({1'b0, bus.rxData_PL} > MAX_LEN);
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_last_word = ({1'b0, r_word_idx} == (r_word_cnt - CNT_W'(1)));

  // State register
  always_ff @(posedge clk_PL or negedge reset_PL) begin
    if (!reset_PL) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; start_PL overrides everything, including a byte taken in the same cycle
  always_comb begin
    w_next = r_state;
    if (bus.start_PL) begin
      w_next = S_LEN;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_IDLE;
        S_LEN:   w_next = w_accept ? (w_len_bad ? S_ERROR : S_DATA) : S_LEN;
        S_DATA:  w_next = (w_accept && w_last_byte && w_last_word) ? S_CHK : S_DATA;
        S_CHK:   w_next = w_accept ? ((bus.rxData_PL == r_chk) ? S_DONE : S_ERROR) : S_CHK;
        S_DONE:  w_next = S_DONE;
        S_ERROR: w_next = S_ERROR;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the upcoming state so they register alongside it
  always_comb begin
    w_rx_ready_nx = 1'b0;
    w_done_nx     = 1'b0;
    w_error_nx    = 1'b0;
    w_core_rst_nx = 1'b1;
    case (w_next)
      S_LEN, S_DATA, S_CHK: w_rx_ready_nx = 1'b1;
      S_DONE: begin
        w_done_nx     = 1'b1;
        w_core_rst_nx = 1'b0;
      end
      S_ERROR: w_error_nx = 1'b1;
      default: w_rx_ready_nx = 1'b0;
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk_PL or negedge reset_PL) begin
    if (!reset_PL) begin
      r_rx_ready <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_core_rst <= 1'b1;
    end else begin
      r_rx_ready <= w_rx_ready_nx;
      r_done     <= w_done_nx;
      r_error    <= w_error_nx;
      r_core_rst <= w_core_rst_nx;
    end
  end

  // Word assembly, checksum and one-cycle memory write pulse after each fourth byte
  always_ff @(posedge clk_PL or negedge reset_PL) begin
    if (!reset_PL) begin
      r_im_we    <= 1'b0;
      r_im_addr  <= '0;
      r_im_data  <= '0;
      r_word     <= '0;
      r_word_cnt <= '0;
      r_word_idx <= '0;
      r_byte_idx <= 2'd0;
      r_chk      <= 8'd0;
    end else begin
      r_im_we <= 1'b0;
      if (bus.start_PL) begin
        r_byte_idx <= 2'd0;
      end else if (w_accept) begin
        case (r_state)
          S_LEN: begin
            if (!w_len_bad) begin
              r_word_cnt <= bus.rxData_PL[CNT_W-1:0];
              r_word_idx <= '0;
              r_byte_idx <= 2'd0;
              r_chk      <= 8'd0;
            end
          end
          S_DATA: begin
            r_word[{r_byte_idx, 3'b000} +: 8] <= bus.rxData_PL;
            r_chk      <= f_xor8(r_chk, bus.rxData_PL);
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_last_byte) begin
              r_im_we    <= 1'b1;
              r_im_addr  <= r_word_idx;
              r_im_data  <= {bus.rxData_PL, r_word[WORD_W-9:0]};
              r_word_idx <= r_word_idx + ADDR_W'(1);
            end
          end
          default: r_im_we <= 1'b0;
        endcase
      end
    end
  end

  assign bus.rxReady_OUT   = r_rx_ready;
  assign bus.imWe_OUT      = r_im_we;
  assign bus.imAddr_OUT    = r_im_addr;
  assign bus.imData_OUT    = r_im_data;
  assign bus.coreReset_OUT = r_core_rst;
  assign bus.done_OUT      = r_done;
  assign bus.error_OUT     = r_error;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of image loads, abort and reset sequences, then random loads
// compared against an image-level model of the expected memory writes and final status.
module tb_program_loader;
  localparam int ADDR_W = 5;
  localparam int WORD_W = 32;
  localparam int MAXW   = 1 << ADDR_W;

  typedef struct {
    logic [7:0] len;
    logic [7:0] chk_flip;
    int         gap;
    bit         rnd;
    bit         exp_done;
    bit         exp_err;
    int         exp_wr;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();
  program_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk_PL   (clk),
    .reset_PL (rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [ADDR_W+WORD_W-1:0] obs_q[$];
  logic [ADDR_W+WORD_W-1:0] exp_q[$];
  logic [7:0]               data_q[$];
  vec_t                     vecs[6];
  bit                       model_done;
  bit                       model_err;
  logic                     cap_done;
  logic                     cap_err;
  logic                     cap_crst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Record every write pulse seen on the memory side
  always @(negedge clk) begin
    if (bus.imWe_OUT === 1'b1) obs_q.push_back({bus.imAddr_OUT, bus.imData_OUT});
  end

  // Called at a falling edge; returns at the falling edge after the byte was taken
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    bus.rxValid_PL = 1'b1;
    bus.rxData_PL  = b;
    while (bus.rxReady_OUT !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (bus.rxReady_OUT !== 1'b1) begin
      check("ready_timeout", 64'(bus.rxReady_OUT), 64'd1);
      bus.rxValid_PL = 1'b0;
    end else begin
      @(negedge clk);
      bus.rxValid_PL = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    bus.start_PL = 1'b1;
    @(negedge clk);
    bus.start_PL = 1'b0;
  endtask

  task automatic fill_fixed();
    data_q = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00};
  endtask

  task automatic fill_rand(input int n);
    data_q.delete();
    for (int i = 0; i < n; i++) data_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Drive one image and compare the writes against those the image itself implies
  task automatic run_load(input logic [7:0] len, input logic [7:0] chk_flip, input int gap);
    logic [7:0]  csum;
    logic [31:0] wv;
    bit          len_ok;
    int          n;
    obs_q.delete();
    exp_q.delete();
    csum   = 8'h00;
    len_ok = (len != 8'd0) && (int'(len) <= MAXW);
    pulse_start();
    send_byte(len, gap);
    if (len_ok) begin
      for (int i = 0; i < int'(len) * 4; i++) begin
        send_byte(data_q[i], gap);
        csum = csum ^ data_q[i];
      end
      for (int w = 0; w < int'(len); w++) begin
        wv = 32'(data_q[4*w]) + (32'(data_q[4*w+1]) << 8)
           + (32'(data_q[4*w+2]) << 16) + (32'(data_q[4*w+3]) << 24);
        exp_q.push_back({ADDR_W'(w), wv});
      end
      send_byte(csum ^ chk_flip, gap);
    end
    model_done = len_ok && (chk_flip == 8'h00);
    model_err  = !model_done;
    cap_done   = bus.done_OUT;
    cap_err    = bus.error_OUT;
    cap_crst   = bus.coreReset_OUT;
    repeat (2) @(negedge clk);
    check("wr_count", 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("wr_entry", 64'(obs_q[i]), 64'(exp_q[i]));
    check("ready_after", 64'(bus.rxReady_OUT), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.rxReady_OUT), 64'd0);
    check({tag, "_we"},    64'(bus.imWe_OUT), 64'd0);
    check({tag, "_addr"},  64'(bus.imAddr_OUT), 64'd0);
    check({tag, "_data"},  64'(bus.imData_OUT), 64'd0);
    check({tag, "_done"},  64'(bus.done_OUT), 64'd0);
    check({tag, "_err"},   64'(bus.error_OUT), 64'd0);
    check({tag, "_crst"},  64'(bus.coreReset_OUT), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rl;
    logic [7:0] rf;
    int         rg;
    bus.start_PL   = 1'b0;
    bus.rxValid_PL = 1'b0;
    bus.rxData_PL  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 64'(bus.rxReady_OUT), 64'd0);
    check("idle_crst", 64'(bus.coreReset_OUT), 64'd1);

    vecs[0] = '{8'h02, 8'h00, 0, 1'b0, 1'b1, 1'b0, 2};
    vecs[1] = '{8'h02, 8'h00, 3, 1'b0, 1'b1, 1'b0, 2};
    vecs[2] = '{8'h02, 8'h01, 0, 1'b0, 1'b0, 1'b1, 2};
    vecs[3] = '{8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b1, 0};
    vecs[4] = '{8'h21, 8'h00, 0, 1'b0, 1'b0, 1'b1, 0};
    vecs[5] = '{8'h20, 8'h00, 0, 1'b1, 1'b1, 1'b0, 32};

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].rnd) fill_rand(4 * int'(vecs[v].len));
      else fill_fixed();
      run_load(vecs[v].len, vecs[v].chk_flip, vecs[v].gap);
      check("vec_done", 64'(cap_done), 64'(vecs[v].exp_done));
      check("vec_err",  64'(cap_err),  64'(vecs[v].exp_err));
      check("vec_crst", 64'(cap_crst), 64'(!vecs[v].exp_done));
      check("vec_nwr",  64'(obs_q.size()), 64'(vecs[v].exp_wr));
      if (v == 0 && obs_q.size() == 2) begin
        check("normal_w0", 64'(obs_q[0]), 64'({5'd0, 32'h00500093}));
        check("normal_w1", 64'(obs_q[1]), 64'({5'd1, 32'h00108133}));
      end
    end

    // Abort after six data bytes; the byte offered alongside start must be dropped
    obs_q.delete();
    pulse_start();
    send_byte(8'h02, 0);
    data_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    for (int i = 0; i < 6; i++) send_byte(data_q[i], 0);
    bus.rxValid_PL = 1'b1;
    bus.rxData_PL  = 8'h77;
    bus.start_PL   = 1'b1;
    @(negedge clk);
    bus.start_PL   = 1'b0;
    bus.rxValid_PL = 1'b0;
    check("abort_done",  64'(bus.done_OUT), 64'd0);
    check("abort_err",   64'(bus.error_OUT), 64'd0);
    check("abort_crst",  64'(bus.coreReset_OUT), 64'd1);
    check("abort_ready", 64'(bus.rxReady_OUT), 64'd1);
    send_byte(8'h01, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    check("abort_reload_done", 64'(bus.done_OUT), 64'd1);
    check("abort_reload_crst", 64'(bus.coreReset_OUT), 64'd0);
    repeat (2) @(negedge clk);
    check("abort_nwr", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      check("abort_w_first", 64'(obs_q[0]), 64'({5'd0, 32'hD4C3B2A1}));
      check("abort_w_final", 64'(obs_q[1]), 64'({5'd0, 32'h00000013}));
    end

    // Random images, lengths, stalls and occasional corrupted checksums
    for (int r = 0; r < 8; r++) begin
      rl = 8'($urandom_range(1, MAXW));
      rg = $urandom_range(0, 2);
      rf = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      fill_rand(4 * int'(rl));
      run_load(rl, rf, rg);
      check("rnd_done", 64'(cap_done), 64'(model_done));
      check("rnd_err",  64'(cap_err),  64'(model_err));
      check("rnd_crst", 64'(cap_crst), 64'(!model_done));
    end

    // Asynchronous reset in the middle of a data phase
    pulse_start();
    send_byte(8'h02, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + 8'(i)), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    obs_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_idle_ready", 64'(bus.rxReady_OUT), 64'd0);
    check("arst_idle_crst", 64'(bus.coreReset_OUT), 64'd1);
    check("arst_no_writes", 64'(obs_q.size()), 64'd0);
    fill_fixed();
    run_load(8'h01, 8'h00, 0);
    check("arst_reload_done", 64'(cap_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader directly upstream of the instruction memory in the single-cycle core.
- Receives a program as a byte stream over a valid/ready interface.
- Assembles little-endian 32-bit words and writes them into instruction memory word slots 0..2^ADDR_W-1.
- Holds the datapath in reset until a complete, checksum-verified image is loaded, then releases it.

Parameters:
ADDR_W, 5, instruction-memory word-address width (32 words; matches PC[6:2] indexing)
WORD_W, 32, instruction word width; fixed at 4 bytes

Ports:
clk_PL  input  1  clock; all state changes on rising edge
reset_PL  input  1  asynchronous, active-low reset
start_PL  input  1  one-cycle pulse; begins a new load (aborts any load in progress)
rxData_PL  input  8  incoming byte
rxValid_PL  input  1  rxData_PL valid
rxReady_OUT  output  1  loader can accept a byte this cycle
imWe_OUT  output  1  instruction-memory write enable, one-cycle pulse per word
imAddr_OUT  output  ADDR_W  instruction-memory word address
imData_OUT  output  WORD_W  instruction word to write
coreReset_OUT  output  1  active-high reset to datapath (drives reset_DP)
done_OUT  output  1  image loaded and verified
error_OUT  output  1  load failed (bad length or checksum)

Behaviour:
- Reset (reset_PL=0, async):
  - state=IDLE; rxReady_OUT=0, imWe_OUT=0, imAddr_OUT=0, imData_OUT=0, done_OUT=0, error_OUT=0, coreReset_OUT=1.
  - Word index, byte index and checksum cleared.
- Handshake: a byte transfers on a rising edge where rxValid_PL & rxReady_OUT.
  - rxReady_OUT=1 only in LEN, DATA and CHK. It is registered and stays high during write pulses, so back-to-back bytes are accepted every cycle.
  - Gaps in rxValid_PL stall the FSM with no state change.
- States:
  - IDLE: waits for start_PL. Go to LEN.
  - LEN: accept byte L.
    - L==0 or L>2^ADDR_W: go to ERROR.
    - Otherwise: store wordCount=L, clear wordIdx, byteIdx and checksum, go to DATA.
  - DATA:
    - Each accepted byte is placed at bits [8*byteIdx+7 : 8*byteIdx] of the word under assembly (byte0 = LSB), and XORed into the running 8-bit checksum. byteIdx wraps 3→0.
    - On acceptance of byte 3: on the following cycle imWe_OUT=1 for exactly one cycle, with imAddr_OUT=wordIdx and imData_OUT=assembled word. wordIdx then increments.
    - When the L-th word's byte 3 is accepted, go to CHK. That last word's write pulse occurs in the first cycle of CHK.
  - CHK: accept one byte. Equal to running checksum: go to DONE. Otherwise: go to ERROR.
  - DONE: done_OUT=1, coreReset_OUT=0, rxReady_OUT=0. Output changes are registered, i.e. visible in the cycle after the checksum byte is accepted.
  - ERROR: error_OUT=1, coreReset_OUT=1, rxReady_OUT=0.
- start_PL in any state (IDLE, LEN, DATA, CHK, DONE, ERROR):
  - Next state is LEN; done_OUT=0 and error_OUT=0; coreReset_OUT=1 from the next edge.
  - Partial word discarded; any pending write pulse for a completed word still issues.
  - start_PL has priority over a byte accepted in the same cycle (that byte is dropped).
- Memory: words never written keep their prior contents. imAddr_OUT and imData_OUT hold their last values between pulses.
- Reset mid-load: immediate return to IDLE, no write pulse, coreReset_OUT=1.

Test Plan:
- Normal load:
  - Stimulus: start; L=0x02; bytes 93 00 50 00 33 81 10 00 back-to-back; checksum 0x61.
  - Response: imWe pulses at addr 0 with 0x00500093 and addr 1 with 0x00108133. done_OUT=1 and coreReset_OUT=0 one cycle after the checksum byte is accepted.
- Stalled stream:
  - Stimulus: same image with rxValid_PL deasserted 3 cycles between every byte.
  - Response: identical writes and final state; no duplicate imWe pulses.
- Bad checksum:
  - Stimulus: same image with checksum 0x60.
  - Response: error_OUT=1, coreReset_OUT=1, done_OUT=0; both words still written.
- Length bounds:
  - L=0x00: ERROR with no writes.
  - L=0x21: ERROR.
  - L=0x20 with 128 bytes and correct checksum: 32 writes at addr 0..31, then DONE.
- Abort:
  - Stimulus: start_PL after 6 data bytes; then a full 1-word load of 13 00 00 00 with checksum 0x13.
  - Response: only addr 0 written (0x00000013 overwriting the first attempt's word); DONE.
- Async reset mid-load:
  - Stimulus: reset_PL low mid-cycle during DATA.
  - Response: all outputs at reset values immediately; start_PL required to reload.
